wb_stream_reader_sched: RTL and testbench

WB_STREAM_READER_SCHED -- requirements
Module: wb_stream_reader_sched

---
 rtl/wb_stream_reader_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_wb_stream_reader_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_reader_sched.sv
// Descriptor scheduler for a Wishbone stream reader: queues buffer descriptors and
// programs each one into the reader's register bank, then waits for its completion irq.
module wb_stream_reader_sched #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int DESC_AW       = 2,
  parameter int MAX_BURST_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [WB_AW-1:0]   desc_adr_i,
  input  logic [WB_AW-1:0]   desc_size_i,
  input  logic [7:0]         desc_burst_i,
  input  logic               desc_valid_i,
  output logic               desc_ready_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               irq_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        done_cnt_o,
  output logic               bad_desc_o,
  output logic               err_o
);

  localparam int BYTES     = WB_DW / 8;
  localparam int MAX_WORDS = MAX_BURST_LEN / BYTES;
  localparam int DEPTH_N   = 32'd1 << DESC_AW;
  localparam logic [DESC_AW:0]   DEPTH     = {1'b1, {DESC_AW{1'b0}}};
  localparam logic [DESC_AW:0]   CNT_ZERO  = {(DESC_AW+1){1'b0}};
  localparam logic [DESC_AW:0]   CNT_ONE   = {{DESC_AW{1'b0}}, 1'b1};
  localparam logic [DESC_AW-1:0] PTR_ZERO  = {DESC_AW{1'b0}};
  localparam logic [DESC_AW-1:0] PTR_ONE   = DESC_AW'(1'b1);
  localparam logic [WB_AW-1:0]   ADR_ZERO  = {WB_AW{1'b0}};
  localparam logic [WB_AW-1:0]   ADR_ONE   = WB_AW'(1'b1);
  localparam logic [WB_DW-1:0]   DAT_ZERO  = {WB_DW{1'b0}};
  localparam logic [BYTES-1:0]   SEL_ZERO  = {BYTES{1'b0}};
  localparam logic [BYTES-1:0]   SEL_ALL   = {BYTES{1'b1}};
  localparam logic [WB_AW-1:0]   REG_CSR   = WB_AW'(8'h00);
  localparam logic [WB_AW-1:0]   REG_START = WB_AW'(8'h04);
  localparam logic [WB_AW-1:0]   REG_SIZE  = WB_AW'(8'h08);
  localparam logic [WB_AW-1:0]   REG_BURST = WB_AW'(8'h0C);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CHECK    = 4'd1,
    S_WR_ADR   = 4'd2,
    S_WR_SIZE  = 4'd3,
    S_WR_BURST = 4'd4,
    S_WR_START = 4'd5,
    S_WAIT_IRQ = 4'd6,
    S_WR_CLR   = 4'd7,
    S_HALT     = 4'd8
  } state_t;

  logic [WB_AW-1:0]   adr_mem_r   [DEPTH_N];
  logic [WB_AW-1:0]   size_mem_r  [DEPTH_N];
  logic [7:0]         burst_mem_r [DEPTH_N];
  logic [DESC_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [DESC_AW:0]   count_r, count_nxt_s;
  logic               ready_r, push_s, pop_s;

  state_t             state_r, wr_next_s;
  logic [WB_AW-1:0]   w_adr_r, w_size_r;
  logic [7:0]         w_burst_r;
  logic [WB_AW-1:0]   adr_r, wr_adr_s, stride_s, div_s;
  logic [WB_DW-1:0]   dat_r, wr_dat_s;
  logic [BYTES-1:0]   sel_r;
  logic               we_r, cyc_r, stb_r, busy_r, done_r, bad_r, err_r;
  logic [15:0]        done_cnt_r;
  logic               burst_ok_s, size_ok_s, unused_s;

  assign push_s = desc_valid_i && ready_r;
  assign pop_s  = (state_r == S_IDLE) && en_i && (count_r != CNT_ZERO);

  // Queue occupancy for the next cycle.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != DEPTH);
    end
  end

  // Descriptor storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      adr_mem_r[wr_ptr_r]   <= desc_adr_i;
      size_mem_r[wr_ptr_r]  <= desc_size_i;
      burst_mem_r[wr_ptr_r] <= desc_burst_i;
    end
  end

  // Descriptor legality; the divisor is forced to 1 when the burst is out of range.
  always_comb begin
    stride_s   = WB_AW'(w_burst_r) * WB_AW'(BYTES);
    burst_ok_s = (w_burst_r >= 8'd2) && (int'(w_burst_r) <= MAX_WORDS);
    div_s      = burst_ok_s ? stride_s : ADR_ONE;
    size_ok_s  = (w_size_r != ADR_ZERO) && ((w_size_r % div_s) == ADR_ZERO);
  end

  // Register address, data and successor for the write owned by the current state.
  always_comb begin
    wr_adr_s  = REG_CSR;
    wr_dat_s  = DAT_ZERO;
    wr_next_s = S_IDLE;
    case (state_r)
      S_WR_ADR:   begin wr_adr_s = REG_START; wr_dat_s = WB_DW'(w_adr_r);   wr_next_s = S_WR_SIZE;  end
      S_WR_SIZE:  begin wr_adr_s = REG_SIZE;  wr_dat_s = WB_DW'(w_size_r);  wr_next_s = S_WR_BURST; end
      S_WR_BURST: begin wr_adr_s = REG_BURST; wr_dat_s = WB_DW'(w_burst_r); wr_next_s = S_WR_START; end
      S_WR_START: begin wr_adr_s = REG_CSR;   wr_dat_s = WB_DW'(2'd1);      wr_next_s = S_WAIT_IRQ; end
      S_WR_CLR:   begin wr_adr_s = REG_CSR;   wr_dat_s = WB_DW'(2'd2);      wr_next_s = S_IDLE;     end
      default:    begin wr_adr_s = REG_CSR;   wr_dat_s = DAT_ZERO;          wr_next_s = S_IDLE;     end
    endcase
  end

  // Sequencer: pops, validates and programs descriptors with registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      w_adr_r    <= ADR_ZERO;
      w_size_r   <= ADR_ZERO;
      w_burst_r  <= 8'd0;
      adr_r      <= ADR_ZERO;
      dat_r      <= DAT_ZERO;
      sel_r      <= SEL_ZERO;
      we_r       <= 1'b0;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bad_r      <= 1'b0;
      err_r      <= 1'b0;
      done_cnt_r <= 16'd0;
    end else begin
      done_r <= 1'b0;
      bad_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            w_adr_r   <= adr_mem_r[rd_ptr_r];
            w_size_r  <= size_mem_r[rd_ptr_r];
            w_burst_r <= burst_mem_r[rd_ptr_r];
            busy_r    <= 1'b1;
            state_r   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (burst_ok_s && size_ok_s) begin
            state_r <= S_WR_ADR;
          end else begin
            bad_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        // Entering a write state with cyc low gives the mandatory idle bus cycle.
        S_WR_ADR, S_WR_SIZE, S_WR_BURST, S_WR_START, S_WR_CLR: begin
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
            we_r  <= 1'b1;
            sel_r <= SEL_ALL;
            adr_r <= wr_adr_s;
            dat_r <= wr_dat_s;
          end else if (wbm_err_i) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_HALT;
          end else if (wbm_ack_i) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= wr_next_s;
            if (state_r == S_WR_CLR) begin
              done_r     <= 1'b1;
              done_cnt_r <= done_cnt_r + 16'd1;
              busy_r     <= 1'b0;
            end
          end
        end
        S_WAIT_IRQ: begin
          if (irq_i) state_r <= S_WR_CLR;
        end
        S_HALT: state_r <= S_HALT;
        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign unused_s     = ^wbm_dat_i;
  assign desc_ready_o = ready_r;
  assign wbm_adr_o    = adr_r;
  assign wbm_dat_o    = dat_r;
  assign wbm_sel_o    = sel_r;
  assign wbm_we_o     = we_r;
  assign wbm_cyc_o    = cyc_r;
  assign wbm_stb_o    = stb_r;
  assign wbm_cti_o    = 3'b000;
  assign wbm_bte_o    = 2'b00;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign done_cnt_o   = done_cnt_r;
  assign bad_desc_o   = bad_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_wb_stream_reader_sched.sv
// Directed bench for wb_stream_reader_sched: a Wishbone slave model answers writes,
// a scoreboard of expected register writes is drained by a bus monitor.
module tb_wb_stream_reader_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] desc_adr = 32'd0;
  logic [31:0] desc_size = 32'd0;
  logic [7:0]  desc_burst = 8'd0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err;
  logic        irq = 1'b0;
  logic        busy, done, bad, err_o;
  logic [15:0] done_cnt;
  logic        err_adr_en = 1'b0;
  logic [31:0] err_adr = 32'd0;

  int checks = 0;
  int failures = 0;
  int n_wr = 0, n_start = 0, n_clr = 0, n_done = 0, n_bad = 0;
  logic prev_hs = 1'b0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  wb_stream_reader_sched dut (
    .clk(clk), .rst(rst), .en_i(en),
    .desc_adr_i(desc_adr), .desc_size_i(desc_size), .desc_burst_i(desc_burst),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_dat_i(32'hDEAD_BEEF), .wbm_ack_i(ack), .wbm_err_i(err),
    .irq_i(irq), .busy_o(busy), .done_o(done), .done_cnt_o(done_cnt),
    .bad_desc_o(bad), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: answers each strobe one cycle later, with err on the selected address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else if (cyc && stb && !ack && !err) begin
      if (err_adr_en && adr == err_adr) err <= 1'b1;
      else ack <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every completed write and counts pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_hs) chk("bus_gap_cyc", 64'(cyc), 64'd0);
      prev_hs = cyc && stb && ack;
      if (cyc && stb && ack) begin
        n_wr++;
        chk("wr_ctrl", 64'({we, sel, cti, bte}), 64'({1'b1, 4'hF, 3'b000, 2'b00}));
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("wr_adr_dat", {adr, dat}, exp_q.pop_front());
        if (adr == 32'h0 && dat == 32'h1) n_start++;
        if (adr == 32'h0 && dat == 32'h2) n_clr++;
      end
      if (done) n_done++;
      if (bad) n_bad++;
    end
  end

  task automatic exp_desc(input logic [31:0] a, input logic [31:0] s, input logic [7:0] b);
    exp_q.push_back({32'h4, a});
    exp_q.push_back({32'h8, s});
    exp_q.push_back({32'hC, 24'd0, b});
    exp_q.push_back({32'h0, 32'h1});
    exp_q.push_back({32'h0, 32'h2});
  endtask

  task automatic push_desc(input logic [31:0] a, input logic [31:0] s, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    desc_adr = a; desc_size = s; desc_burst = b; desc_valid = 1'b1;
    while (!desc_ready && t < 200) begin @(negedge clk); t++; end
    chk("push_accepted", 64'(desc_ready), 64'd1);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic serve_irq();
    int t, st0, cl0;
    st0 = n_start; cl0 = n_clr; t = 0;
    while (n_start == st0 && t < 400) begin @(negedge clk); #1; t++; end
    chk("start_wr_seen", 64'(n_start > st0), 64'd1);
    repeat (3) @(negedge clk);
    irq = 1'b1;
    t = 0;
    while (n_clr == cl0 && t < 400) begin @(negedge clk); #1; t++; end
    chk("clr_wr_seen", 64'(n_clr > cl0), 64'd1);
    irq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t, d0, b0, wr0, st0, cl0;
    // Reset values while rst is held.
    #2;
    chk("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'd0);
    chk("rst_adr_dat_sel", {adr, dat} | 64'(sel), 64'd0);
    chk("rst_flags", 64'({busy, done, bad, err_o}), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(desc_ready), 64'd1);

    // Single descriptor end to end.
    en = 1'b1;
    d0 = n_done;
    exp_desc(32'h40, 32'h40, 8'd4);
    push_desc(32'h40, 32'h40, 8'd4);
    serve_irq();
    repeat (2) @(negedge clk);
    chk("single_done_cnt", 64'(done_cnt), 64'd1);
    chk("single_done_pulses", 64'(n_done - d0), 64'd1);
    chk("single_busy_idle", 64'(busy), 64'd0);

    // Fill the queue with en low, fifth descriptor held off, then drain in order.
    do_reset();
    en = 1'b0;
    d0 = n_done;
    exp_desc(32'h100, 32'h20, 8'd2); push_desc(32'h100, 32'h20, 8'd2);
    exp_desc(32'h200, 32'h30, 8'd3); push_desc(32'h200, 32'h30, 8'd3);
    exp_desc(32'h300, 32'h40, 8'd8); push_desc(32'h300, 32'h40, 8'd8);
    exp_desc(32'h400, 32'h80, 8'd4); push_desc(32'h400, 32'h80, 8'd4);
    chk("full_ready_low", 64'(desc_ready), 64'd0);
    chk("full_not_busy", 64'(busy), 64'd0);
    desc_adr = 32'h500; desc_size = 32'h60; desc_burst = 8'd6; desc_valid = 1'b1;
    exp_desc(32'h500, 32'h60, 8'd6);
    repeat (3) @(negedge clk);
    chk("held_ready_low", 64'(desc_ready), 64'd0);
    en = 1'b1;
    t = 0;
    while (!desc_ready && t < 200) begin @(negedge clk); t++; end
    chk("fifth_accepted", 64'(desc_ready), 64'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    for (int i = 0; i < 5; i++) serve_irq();
    repeat (2) @(negedge clk);
    chk("batch_done_cnt", 64'(done_cnt), 64'd5);
    chk("batch_done_pulses", 64'(n_done - d0), 64'd5);
    chk("batch_sb_drained", 64'(exp_q.size()), 64'd0);

    // Illegal descriptors are rejected without bus traffic.
    do_reset();
    b0 = n_bad;
    wr0 = n_wr;
    push_desc(32'h0, 32'h18, 8'd4);
    push_desc(32'h0, 32'h40, 8'd1);
    push_desc(32'h0, 32'h40, 8'd9);
    push_desc(32'h0, 32'h0, 8'd4);
    push_desc(32'h0, 32'h20, 8'd3);
    repeat (4) @(negedge clk);
    chk("bad_pulses", 64'(n_bad - b0), 64'd5);
    chk("bad_no_writes", 64'(n_wr - wr0), 64'd0);
    exp_desc(32'h80, 32'h40, 8'd2);
    push_desc(32'h80, 32'h40, 8'd2);
    serve_irq();
    repeat (2) @(negedge clk);
    chk("after_bad_done_cnt", 64'(done_cnt), 64'd1);
    chk("after_bad_sb_drained", 64'(exp_q.size()), 64'd0);

    // An irq pulse during WR_SIZE must not short-cut the irq wait.
    do_reset();
    st0 = n_start; cl0 = n_clr;
    exp_desc(32'hC0, 32'h40, 8'd4);
    push_desc(32'hC0, 32'h40, 8'd4);
    t = 0;
    while (!(cyc && adr == 32'h8) && t < 100) begin @(negedge clk); t++; end
    chk("size_wr_active", 64'(cyc && adr == 32'h8), 64'd1);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    t = 0;
    while (n_start == st0 && t < 100) begin @(negedge clk); #1; t++; end
    repeat (20) @(negedge clk);
    chk("early_irq_no_clr", 64'(n_clr - cl0), 64'd0);
    chk("early_irq_busy", 64'(busy), 64'd1);
    irq = 1'b1;
    t = 0;
    while (n_clr == cl0 && t < 100) begin @(negedge clk); #1; t++; end
    irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_irq_done_cnt", 64'(done_cnt), 64'd1);

    // Bus error on BUF_SIZE halts with the queue frozen.
    do_reset();
    en = 1'b0;
    err_adr = 32'h8; err_adr_en = 1'b1;
    exp_q.push_back({32'h4, 32'h1000});
    push_desc(32'h1000, 32'h40, 8'd4);
    push_desc(32'h2000, 32'h40, 8'd4);
    push_desc(32'h3000, 32'h40, 8'd4);
    st0 = n_start;
    en = 1'b1;
    t = 0;
    while (!err_o && t < 200) begin @(negedge clk); t++; end
    chk("halt_err", 64'(err_o), 64'd1);
    chk("halt_busy", 64'(busy), 64'd0);
    wr0 = n_wr;
    repeat (10) @(negedge clk);
    chk("halt_bus_idle", 64'({cyc, stb}), 64'd0);
    push_desc(32'h4000, 32'h40, 8'd4);
    push_desc(32'h5000, 32'h40, 8'd4);
    repeat (10) @(negedge clk);
    chk("halt_queue_frozen", 64'(desc_ready), 64'd0);
    chk("halt_no_writes", 64'(n_wr - wr0), 64'd0);
    chk("halt_no_csr", 64'(n_start - st0), 64'd0);
    chk("halt_err_sticky", 64'(err_o), 64'd1);
    do_reset();
    err_adr_en = 1'b0;
    chk("halt_rst_err", 64'(err_o), 64'd0);
    chk("halt_rst_ready", 64'(desc_ready), 64'd1);

    // Reset while waiting for the irq abandons the descriptor.
    exp_desc(32'h40, 32'h40, 8'd4); push_desc(32'h40, 32'h40, 8'd4);
    exp_desc(32'h80, 32'h80, 8'd4); push_desc(32'h80, 32'h80, 8'd4);
    serve_irq();
    st0 = n_start;
    t = 0;
    while (n_start == st0 && t < 200) begin @(negedge clk); #1; t++; end
    repeat (3) @(negedge clk);
    chk("pre_rst_done_cnt", 64'(done_cnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("wait_rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("wait_rst_busy", 64'(busy), 64'd0);
    chk("wait_rst_ready", 64'(desc_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    irq = 1'b1;
    wr0 = n_wr;
    repeat (10) @(negedge clk);
    irq = 1'b0;
    chk("wait_rst_no_clr", 64'(n_wr - wr0), 64'd0);
    chk("wait_rst_cyc", 64'(cyc), 64'd0);

    // Reset in the middle of a bus cycle drops cyc without waiting for a clock.
    push_desc(32'h40, 32'h40, 8'd4);
    t = 0;
    while (!cyc && t < 100) begin @(negedge clk); t++; end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc_stb", 64'({cyc, stb, we}), 64'd0);
    chk("mid_rst_adr", 64'(adr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr0 = n_wr;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_writes", 64'(n_wr - wr0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
